cov_accum: RTL and testbench

- Parametrised covariance accumulator for the FastICA datapath. Sits downstream of centering and feeds whitening.
- Accepts a block of 2^LOG2_NS centred sample vectors of NCH channels through a valid/ready handshake.
- Accumulates every upper-triangle cross product Xi*Xj (i<=j) in a pipelined MAC array.
- At block end, presents the sample-averaged covariance (sum >>> LOG2_NS) with a completion strobe.

---
 rtl/cov_accum_pkg.sv | 25 ++
 rtl/cov_accum_if.sv | 24 ++
 rtl/cov_accum_pair_mac.sv | 31 +++
 rtl/cov_accum.sv | 105 ++++++++++
 tb/tb_cov_accum.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cov_accum_pkg.sv
// cov_accum shared types and helpers.
// Upper-triangle pair indexing and the block-level state encoding.
package cov_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    DONE
  } state_t;

  function automatic int np(input int nch);
    return nch * (nch + 1) / 2;
  endfunction

  // row-major index of (i,j), i<=j, over the upper triangle
  function automatic int pair_idx(
    input int i,
    input int j,
    input int nch
  );
    return i * nch - (i * (i - 1)) / 2 + (j - i);
  endfunction

endpackage

// File: rtl/cov_accum_if.sv
// cov_accum sample stream interface.
// Sample vector with valid/ready handshake.
interface cov_accum_if #(
  parameter int NCH = 4,
  parameter int DW  = 26
);

  logic              in_valid;
  logic              in_ready;
  logic [NCH*DW-1:0] x;

  modport master (
    output in_valid,
    output x,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  x,
    output in_ready
  );

endinterface

// File: rtl/cov_accum_pair_mac.sv
// cov_pair_mac: one covariance entry.
// Registered product followed by a wide accumulator.
module cov_pair_mac #(
  parameter int DW = 26,
  parameter int AW = 59
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 mul_en,
  input  logic                 acc_en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  localparam int PW = 2 * DW;

  logic signed [PW-1:0] prod;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mul_en) prod <= PW'(a) * PW'(b);
      if (acc_en) acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/cov_accum.sv
// cov_accum: block covariance accumulator.
// Sums upper-triangle cross products, then averages by shift.
module cov_accum
  import cov_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 26,
  parameter int LOG2_NS = 7,
  localparam int PW     = 2 * DW,
  localparam int NP     = np(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  cov_accum_if.slave     s,
  output logic           busy,
  output logic           cov_valid,
  output logic [NP*PW-1:0] cov
);

  localparam int AW = PW + LOG2_NS;
  localparam int CW = LOG2_NS + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_NS) - 1);

  state_t st;
  logic [CW-1:0] cnt;
  logic [1:0] dcnt;
  logic rdy;
  logic prod_v;
  logic take;
  logic go;
  logic signed [AW-1:0] acc [NP];

  assign s.in_ready = rdy;
  assign take = s.in_valid && rdy;
  assign go = start && (st == IDLE || st == DONE);

  for (genvar i = 0; i < NCH; i++) begin : g_row
    for (genvar j = i; j < NCH; j++) begin : g_col
      localparam int K = pair_idx(i, j, NCH);
      cov_pair_mac #(
        .DW(DW),
        .AW(AW)
      ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   (go),
        .mul_en(take),
        .acc_en(prod_v),
        .a     (s.x[i*DW +: DW]),
        .b     (s.x[j*DW +: DW]),
        .acc   (acc[K])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      rdy       <= 1'b0;
      busy      <= 1'b0;
      cov_valid <= 1'b0;
      cov       <= '0;
      prod_v    <= 1'b0;
    end else begin
      cov_valid <= 1'b0;
      prod_v    <= take;
      case (st)
        IDLE, DONE: begin
          if (start) begin
            st   <= ACC;
            cnt  <= '0;
            rdy  <= 1'b1;
            busy <= 1'b1;
          end
        end
        ACC: begin
          if (take) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              st   <= DRAIN;
              rdy  <= 1'b0;
              dcnt <= '0;
            end
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 2'd1;
          // product and accumulate stages settle before dcnt reaches 2
          if (dcnt == 2'd2) begin
            st        <= DONE;
            busy      <= 1'b0;
            cov_valid <= 1'b1;
            for (int k = 0; k < NP; k++)
              cov[k*PW +: PW] <= PW'(acc[k] >>> LOG2_NS);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cov_accum.sv
// tb_cov_accum: scoreboard bench for cov_accum.
// Default 4-channel instance plus a 2-channel, 4-sample instance.
module tb_cov_accum;

  localparam int DW = 26;
  localparam int PW = 2 * DW;
  localparam int NB = 10;
  localparam int NS = 128;
  localparam int WW = NB * PW;

  typedef struct {
    logic [WW-1:0] v;
    int            t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_b = 1'b0;
  logic start_s = 1'b0;
  logic busy_b, cv_b, busy_s, cv_s;
  logic [NB*PW-1:0] cov_b;
  logic [3*PW-1:0] cov_s;

  always #5 clk = ~clk;

  cov_accum_if #(.NCH(4), .DW(DW)) ib ();
  cov_accum_if #(.NCH(2), .DW(DW)) is ();

  cov_accum u_big (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .s        (ib),
    .busy     (busy_b),
    .cov_valid(cv_b),
    .cov      (cov_b)
  );

  cov_accum #(
    .NCH    (2),
    .DW     (DW),
    .LOG2_NS(2)
  ) u_small (
    .clk      (clk),
    .rst      (rst),
    .start    (start_s),
    .s        (is),
    .busy     (busy_s),
    .cov_valid(cv_s),
    .cov      (cov_s)
  );

  exp_t qb[$];
  exp_t qs[$];
  exp_t eb, es;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last = 0;
  logic pv_b = 1'b0;
  logic pv_s = 1'b0;

  longint E0[NB] = '{1, 2, 3, 4, 4, 6, 8, 9, 12, 16};
  longint E1[NB] = '{1000000, -1000000, 0, 0, 1000000, 0, 0, 0, 0, 0};
  longint E2 = 64'sd1125899906842624;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WW-1:0] act,
                     input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] vec(input int scn, input int n);
    logic [4*DW-1:0] v;
    int a;
    v = '0;
    case (scn)
      0: for (int c = 0; c < 4; c++) v[c*DW +: DW] = DW'(c + 1);
      1: begin
        a = (n % 2 == 0) ? 1000 : -1000;
        v[0 +: DW]  = DW'(a);
        v[DW +: DW] = DW'(-a);
      end
      2: for (int c = 0; c < 4; c++) v[c*DW +: DW] = DW'(-(1 << 25));
      default: for (int c = 0; c < 4; c++) v[c*DW +: DW] = DW'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [WW-1:0] expb(input int scn);
    logic [WW-1:0] v;
    longint t;
    v = '0;
    for (int k = 0; k < NB; k++) begin
      t = (scn == 0) ? E0[k] : (scn == 1) ? E1[k] : E2;
      v[k*PW +: PW] = PW'(t);
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (cv_b) begin
      chk("big_pulse_width", WW'(pv_b), '0);
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL big_unexpected: cov_valid with empty queue");
      end else begin
        eb = qb.pop_front();
        chk("big_cov", cov_b, eb.v);
        chk("big_latency", WW'(cyc), WW'(eb.t));
      end
    end
    pv_b = cv_b;
  end

  always @(negedge clk) begin
    if (cv_s) begin
      chk("small_pulse_width", WW'(pv_s), '0);
      if (qs.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_unexpected: cov_valid with empty queue");
      end else begin
        es = qs.pop_front();
        chk("small_cov", WW'(cov_s), es.v);
        chk("small_latency", WW'(cyc), WW'(es.t));
      end
    end
    pv_s = cv_s;
  end

  task automatic do_start();
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
  endtask

  task automatic send_b(input int scn, input int nsamp, input int bub,
                        input int st_at);
    int n = 0;
    int budget = 0;
    bit v;
    while (n < nsamp && budget < 4000) begin
      @(negedge clk);
      budget++;
      v = ($urandom_range(99) >= bub);
      ib.in_valid = v;
      ib.x = vec(scn, n);
      start_b = (st_at >= 0 && n == st_at);
      if (v && ib.in_ready) begin
        n++;
        last = cyc + 1;
      end
    end
    checks++;
    if (n < nsamp) begin
      errors++;
      $display("FAIL big_accept_timeout: got %0d want %0d", n, nsamp);
    end
    if (nsamp == NS) qb.push_back('{v: expb(scn), t: last + 3});
  endtask

  task automatic trail_b(input bit st);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ib.in_valid = 1'b1;
      ib.x = vec(9, 0);
      start_b = st && (i == 0);
      chk("trail_ready", WW'(ib.in_ready), '0);
      chk("trail_busy", WW'(busy_b), WW'(i < 3));
    end
    @(negedge clk);
    ib.in_valid = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_q();
    int b = 0;
    while ((qb.size() != 0 || qs.size() != 0) && b < 50) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (qb.size() != 0 || qs.size() != 0) begin
      errors++;
      $display("FAIL result_timeout: pending big=%0d small=%0d",
               qb.size(), qs.size());
    end
  endtask

  task automatic chk_reset();
    chk("rst_ready", WW'(ib.in_ready), '0);
    chk("rst_busy", WW'(busy_b), '0);
    chk("rst_valid", WW'(cv_b), '0);
    chk("rst_cov", cov_b, '0);
  endtask

  initial begin
    int b;
    ib.in_valid = 1'b0;
    ib.x = '0;
    is.in_valid = 1'b0;
    is.x = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    chk("rst_small_ready", WW'(is.in_ready), '0);
    chk("rst_small_cov", WW'(cov_s), '0);
    rst = 1'b0;

    do_start();
    send_b(0, NS, 0, -1);
    trail_b(1'b0);
    wait_q();

    do_start();
    send_b(1, NS, 0, -1);
    trail_b(1'b0);
    wait_q();

    do_start();
    send_b(2, NS, 0, -1);
    trail_b(1'b0);
    wait_q();

    do_start();
    send_b(0, NS, 40, 60);
    trail_b(1'b1);
    wait_q();

    do_start();
    send_b(1, 50, 0, -1);
    @(negedge clk);
    rst = 1'b1;
    ib.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_reset();

    do_start();
    send_b(0, NS, 0, -1);
    @(negedge clk);
    ib.in_valid = 1'b0;
    b = 0;
    while (!cv_b && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("done_seen", WW'(cv_b), WW'(1));
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("restart_valid", WW'(cv_b), '0);
    chk("restart_ready", WW'(ib.in_ready), WW'(1));
    send_b(1, NS, 0, -1);
    trail_b(1'b0);
    wait_q();

    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      is.in_valid = 1'b1;
      is.x = (n == 0) ? {DW'(-1), DW'(1)} : '0;
      chk("small_ready", WW'(is.in_ready), WW'(1));
      if (n == 3)
        qs.push_back('{v: WW'({PW'(0), PW'(-1), PW'(0)}), t: cyc + 4});
    end
    @(negedge clk);
    is.in_valid = 1'b0;
    chk("small_ready_drop", WW'(is.in_ready), '0);
    wait_q();

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
